// File: rtl/powlib_swissarb.sv
// powlib_swissarb
//   N-way arbiter feeding one shared FIFO write port. Round-robin search
//   from a rotation pointer. With ELOCK=1 the grant stays on one requester
//   until its packet ends (inlast). With ELOCK=0 the grant rotates after
//   every beat. The output stage is one register, so a beat appears one
//   cycle after it is accepted, and back-to-back beats pass at one per cycle.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous, active-low reset
//   invld    per-requester valid                       [N]
//   indata   requester i data at [i*W +: W]            [N*W]
//   inlast   per-requester last beat of packet         [N]
//   inrdy    per-requester accept, at most one bit set [N]
//   outvld   registered valid toward FIFO
//   outdata  registered data                           [W]
//   outlast  registered last
//   outidx   requester that sourced the output beat    [IW]
//   outrdy   FIFO can accept
module powlib_swissarb #(
    parameter  int N     = 4,
    parameter  int W     = 8,
    parameter  int ELOCK = 1,
    localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   invld,
    input  logic [N*W-1:0] indata,
    input  logic [N-1:0]   inlast,
    output logic [N-1:0]   inrdy,
    output logic           outvld,
    output logic [W-1:0]   outdata,
    output logic           outlast,
    output logic [IW-1:0]  outidx,
    input  logic           outrdy
);

    typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       ptr, ptr_nxt;
    logic [IW-1:0]       lidx, lidx_nxt;
    logic [IW-1:0]       gnt, gnt_inc;
    logic                ld, xfer;
    logic [N-1:0][W-1:0] lane_data;

    assign lane_data = indata;

    // Grant select. Scan from the highest offset down so that the first
    // valid requester at or above ptr (with wrap) overwrites the others.
    // With nothing valid, gnt stays at ptr and invld[gnt] is 0, so no
    // transfer occurs.
    always_comb begin
        logic [IW-1:0] idx;
        gnt = ptr;
        idx = '0;
        if (state == LOCK) begin
            gnt = lidx;
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                idx = IW'((int'(ptr) + k) % N);
                if (invld[idx]) gnt = idx;
            end
        end
    end

    // Reset gating keeps inrdy low while reset is held, whatever invld does.
    assign ld      = rst & (~outvld | outrdy);
    assign xfer    = ld & invld[gnt];
    assign gnt_inc = (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;

    for (genvar g = 0; g < N; g++) begin : g_rdy
        assign inrdy[g] = xfer & (gnt == IW'(g));
    end

    // Next-state logic. A non-last beat with ELOCK set locks onto the
    // granter. Any other accepted beat returns to ARB and advances ptr
    // past the granter.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        lidx_nxt  = lidx;
        if (xfer) begin
            if (ELOCK != 0 && !inlast[gnt]) begin
                state_nxt = LOCK;
                lidx_nxt  = gnt;
            end else begin
                state_nxt = ARB;
                ptr_nxt   = gnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB;
            ptr   <= '0;
            lidx  <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            lidx  <= lidx_nxt;
        end
    end

    // Output stage. It loads on an accepted beat and otherwise empties on
    // an output transfer. During a stall xfer is 0, so the registers hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outvld  <= 1'b0;
            outdata <= '0;
            outlast <= 1'b0;
            outidx  <= '0;
        end else if (xfer) begin
            outvld  <= 1'b1;
            outdata <= lane_data[gnt];
            outlast <= inlast[gnt];
            outidx  <= gnt;
        end else if (outrdy) begin
            outvld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_powlib_swissarb.sv
module tb_powlib_swissarb;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        logic [3:0] mask;   // requesters valid this cycle
        logic [3:0] rdy;    // expected inrdy
        logic [1:0] idx;    // expected output index when rdy != 0
    } row_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        outrdy;
    logic [3:0]  invld   [2];
    logic [31:0] indata  [2];
    logic [3:0]  inlast  [2];
    logic [3:0]  inrdy   [2];
    logic        outvld  [2];
    logic [7:0]  outdata [2];
    logic        outlast [2];
    logic [1:0]  outidx  [2];

    // DUT 0 rotates per beat and DUT 1 locks per packet. Only the DUT
    // selected by sel gets stimulus.
    powlib_swissarb #(.N(4), .W(8), .ELOCK(0)) u0 (
        .clk(clk), .rst(rst), .invld(invld[0]), .indata(indata[0]),
        .inlast(inlast[0]), .inrdy(inrdy[0]), .outvld(outvld[0]),
        .outdata(outdata[0]), .outlast(outlast[0]), .outidx(outidx[0]),
        .outrdy(outrdy)
    );

    powlib_swissarb #(.N(4), .W(8), .ELOCK(1)) u1 (
        .clk(clk), .rst(rst), .invld(invld[1]), .indata(indata[1]),
        .inlast(inlast[1]), .inrdy(inrdy[1]), .outvld(outvld[1]),
        .outdata(outdata[1]), .outlast(outlast[1]), .outidx(outidx[1]),
        .outrdy(outrdy)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_fail = 0;
    int   sel = 0;
    int   cyc = 0;
    int   first_acc = -1;
    int   first_ov = -1;
    int   n_out = 0;
    int   out_cyc [64];
    exp_t sbq [$];

    logic [7:0] src_data [4][8];
    logic       src_last [4][8];
    int         src_len  [4];
    int         src_pos  [4];
    logic       hold     [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [1:0] idx, input logic [7:0] data, input logic last);
        exp_t e;
        e.idx = idx; e.data = data; e.last = last;
        sbq.push_back(e);
    endtask

    task automatic load(input int r, input int len, input logic [7:0] base);
        src_len[r] = len;
        src_pos[r] = 0;
        for (int k = 0; k < len; k++) begin
            src_data[r][k] = base + 8'(k);
            src_last[r][k] = (k == len - 1);
        end
    endtask

    task automatic load_mask(input logic [3:0] mask, input logic [7:0] base);
        for (int r = 0; r < 4; r++) begin
            src_len[r] = mask[r] ? 1 : 0;
            src_pos[r] = 0;
            src_data[r][0] = base + 8'(r);
            src_last[r][0] = 1'b1;
        end
    endtask

    function automatic bit pending();
        bit p = 0;
        for (int r = 0; r < 4; r++) if (src_pos[r] < src_len[r]) p = 1;
        return p;
    endfunction

    task automatic drive();
        logic [3:0]  v, l;
        logic [31:0] dt;
        v = '0; l = '0; dt = '0;
        for (int r = 0; r < 4; r++) begin
            if (src_pos[r] < src_len[r] && !hold[r]) begin
                v[r] = 1'b1;
                dt[r*8 +: 8] = src_data[r][src_pos[r]];
                l[r] = src_last[r][src_pos[r]];
            end
        end
        for (int d = 0; d < 2; d++) begin
            invld[d]  = (d == sel) ? v  : 4'b0;
            indata[d] = (d == sel) ? dt : 32'b0;
            inlast[d] = (d == sel) ? l  : 4'b0;
        end
    endtask

    // One cycle: sample at negedge, check output transfer against the
    // scoreboard, then advance the sources past the accepted beats.
    task automatic tick();
        logic [3:0] acc;
        exp_t e;
        @(negedge clk);
        acc = invld[sel] & inrdy[sel];
        chk("inrdy_onehot", 32'($onehot0(inrdy[sel])), 32'd1);
        if (acc != 0 && first_acc < 0) first_acc = cyc;
        if (outvld[sel] && first_ov < 0) first_ov = cyc;
        if (outvld[sel] && outrdy) begin
            if (n_out < 64) out_cyc[n_out] = cyc;
            n_out++;
            if (sbq.size() == 0) begin
                chk("sb_unexpected_beat", 32'(outidx[sel]), 32'hFFFF);
            end else begin
                e = sbq.pop_front();
                chk("out_idx",  32'(outidx[sel]),  32'(e.idx));
                chk("out_data", 32'(outdata[sel]), 32'(e.data));
                chk("out_last", 32'(outlast[sel]), 32'(e.last));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int r = 0; r < 4; r++) if (acc[r]) src_pos[r]++;
        drive();
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while ((sbq.size() != 0 || pending()) && guard < 40) begin
            tick();
            guard++;
        end
        chk(name, 32'(sbq.size()), 32'd0);
    endtask

    task automatic clear_src();
        for (int r = 0; r < 4; r++) begin
            src_len[r] = 0; src_pos[r] = 0; hold[r] = 1'b0;
        end
    endtask

    row_t tbl [14];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'b1111, 4'b0001, 2'd0};
        tbl[1]  = '{4'b1111, 4'b0010, 2'd1};
        tbl[2]  = '{4'b1111, 4'b0100, 2'd2};
        tbl[3]  = '{4'b1111, 4'b1000, 2'd3};
        tbl[4]  = '{4'b1111, 4'b0001, 2'd0};
        tbl[5]  = '{4'b0000, 4'b0000, 2'd0};
        tbl[6]  = '{4'b1001, 4'b1000, 2'd3};
        tbl[7]  = '{4'b0110, 4'b0010, 2'd1};
        tbl[8]  = '{4'b0001, 4'b0001, 2'd0};
        tbl[9]  = '{4'b0001, 4'b0001, 2'd0};
        tbl[10] = '{4'b0100, 4'b0100, 2'd2};
        tbl[11] = '{4'b1100, 4'b1000, 2'd3};
        tbl[12] = '{4'b0000, 4'b0000, 2'd0};
        tbl[13] = '{4'b0110, 4'b0010, 2'd1};

        // Reset holds everything low even with all requesters valid.
        outrdy = 1'b1;
        rst = 1'b0;
        sel = 0;
        clear_src();
        load_mask(4'b1111, 8'h00);
        drive();
        #3;
        chk("rst_outvld",  32'(outvld[0]),  32'd0);
        chk("rst_outdata", 32'(outdata[0]), 32'd0);
        chk("rst_outlast", 32'(outlast[0]), 32'd0);
        chk("rst_outidx",  32'(outidx[0]),  32'd0);
        chk("rst_inrdy",   32'(inrdy[0]),   32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outvld_clk", 32'(outvld[0]), 32'd0);
        chk("rst_inrdy_clk",  32'(inrdy[0]),  32'd0);
        chk("rst_outvld_u1",  32'(outvld[1]), 32'd0);
        clear_src();
        drive();
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        // ELOCK=0 rotation table: one cycle per row, unaccepted beats dropped.
        first_acc = -1; first_ov = -1; n_out = 0;
        for (int i = 0; i < 14; i++) begin
            load_mask(tbl[i].mask, 8'(i * 16));
            drive();
            #1;
            chk("tbl_inrdy", 32'(inrdy[0]), 32'(tbl[i].rdy));
            if (tbl[i].rdy != 0) push(tbl[i].idx, 8'(i * 16 + int'(tbl[i].idx)), 1'b1);
            tick();
            load_mask(4'b0000, 8'h00);
        end
        drive();
        drain("drain_tbl");
        chk("first_out_latency", 32'(first_ov), 32'(first_acc + 1));
        chk("full_throughput",   32'(out_cyc[4] - out_cyc[0]), 32'd4);

        // ELOCK=1: move ptr to 1, then req1's 3-beat packet stays contiguous.
        sel = 1;
        clear_src();
        load(0, 1, 8'h01);
        push(2'd0, 8'h01, 1'b1);
        drive();
        drain("drain_prelude");
        load(0, 1, 8'h02);
        load(1, 3, 8'h40);
        load(2, 1, 8'h60);
        push(2'd1, 8'h40, 1'b0);
        push(2'd1, 8'h41, 1'b0);
        push(2'd1, 8'h42, 1'b1);
        push(2'd2, 8'h60, 1'b1);
        push(2'd0, 8'h02, 1'b1);
        drive();
        drain("drain_lock_pkt");

        // Output stall: the A5 beat holds for 5 cycles, inputs are blocked.
        load(0, 1, 8'hA5);
        push(2'd0, 8'hA5, 1'b1);
        drive();
        #1;
        chk("stall_first_rdy", 32'(inrdy[1]), 32'b0001);
        tick();
        outrdy = 1'b0;
        load(1, 1, 8'h5A);
        drive();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_outvld",  32'(outvld[1]),  32'd1);
            chk("stall_outdata", 32'(outdata[1]), 32'hA5);
            chk("stall_inrdy",   32'(inrdy[1]),   32'd0);
            tick();
        end
        outrdy = 1'b1;
        #1;
        chk("stall_release_rdy", 32'(inrdy[1]), 32'b0010);
        push(2'd1, 8'h5A, 1'b1);
        drain("drain_stall");

        // Locked req3 pauses for 2 cycles; req0 must wait for its packet.
        load(3, 4, 8'h30);
        load(0, 1, 8'h0F);
        push(2'd3, 8'h30, 1'b0);
        push(2'd3, 8'h31, 1'b0);
        push(2'd3, 8'h32, 1'b0);
        push(2'd3, 8'h33, 1'b1);
        push(2'd0, 8'h0F, 1'b1);
        drive();
        #1;
        chk("gap_first_rdy", 32'(inrdy[1]), 32'b1000);
        tick();
        hold[3] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive();
            #1;
            chk("gap_inrdy", 32'(inrdy[1]), 32'd0);
            tick();
        end
        hold[3] = 1'b0;
        drive();
        #1;
        chk("gap_resume_rdy", 32'(inrdy[1]), 32'b1000);
        drain("drain_gap");

        // Reset mid-packet on req2: outputs clear at once, lock discarded.
        load(2, 4, 8'h50);
        push(2'd2, 8'h50, 1'b0);
        drive();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_outvld",  32'(outvld[1]),  32'd0);
        chk("midrst_outdata", 32'(outdata[1]), 32'd0);
        chk("midrst_outidx",  32'(outidx[1]),  32'd0);
        chk("midrst_outlast", 32'(outlast[1]), 32'd0);
        chk("midrst_inrdy",   32'(inrdy[1]),   32'd0);
        sbq.delete();
        clear_src();
        drive();
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        load_mask(4'b1111, 8'h70);
        for (int r = 0; r < 4; r++) push(2'(r), 8'h70 + 8'(r), 1'b1);
        drive();
        #1;
        chk("postrst_first_grant", 32'(inrdy[1]), 32'b0001);
        drain("drain_postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/powlib_swissarb.md
POWLIB_SWISSARB -- requirements
Module: powlib_swissarb

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters; legal range 2..16.
REQ-002 SHALL have parameter W, default 8: data width per requester in bits.
REQ-003 SHALL have parameter ELOCK, default 1: 1 = grant held for a whole packet (until inlast), 0 = grant rotates after every beat.
REQ-004 SHALL use a single clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port invld  input  N  per-requester valid.
REQ-008 SHALL have port indata  input  N*W  requester i data in bits [i*W+W-1 : i*W].
REQ-009 SHALL have port inlast  input  N  per-requester last beat of packet.
REQ-010 SHALL have port inrdy  output  N  per-requester accept; at most one bit set.
REQ-011 SHALL have port outvld  output  1  registered valid toward the shared FIFO write port.
REQ-012 SHALL have port outdata  output  W  registered data.
REQ-013 SHALL have port outlast  output  1  registered last.
REQ-014 SHALL have port outidx  output  max(1,clog2(N))  index of the requester that sourced the current output beat.
REQ-015 SHALL have port outrdy  input  1  FIFO can accept (not full).

Function
REQ-016 SHALL transfer a beat on requester i when invld[i] and inrdy[i] are both 1 on a rising clk edge.
REQ-017 SHALL transfer a beat on the output when outvld and outrdy are both 1 on a rising clk edge.
REQ-018 SHALL compute load enable as ld = !outvld | outrdy.
REQ-019 SHALL drive inrdy[g] = ld & invld[g] for the granted index g; all other inrdy bits SHALL be 0.
REQ-020 SHALL use FSM states ARB and LOCK.
REQ-021 In ARB, SHALL grant combinationally the first requester with invld=1, searching from rotation pointer ptr upward and wrapping N-1 -> 0.
REQ-022 In LOCK, SHALL keep the grant on the locked index regardless of other requesters' invld.
REQ-023 SHALL, on an input transfer, load outdata, outlast and outidx from the granted requester and set outvld=1 on the same edge (1-cycle latency).
REQ-024 SHALL clear outvld on an output transfer when no input transfer occurs on the same edge.
REQ-025 SHALL sustain full throughput (1 beat/cycle) while outrdy=1.
REQ-026 With ELOCK=1: in ARB, an accepted beat with inlast=0 SHALL move the FSM to LOCK on the granted index.
REQ-027 With ELOCK=1: an accepted beat with inlast=1 (in ARB or LOCK) SHALL set ptr = (g+1) mod N and the FSM to ARB.
REQ-028 With ELOCK=0: the FSM SHALL stay in ARB, and every accepted beat SHALL set ptr = (g+1) mod N.
REQ-029 When outvld=1 and outrdy=0, all output registers SHALL hold stable and inrdy SHALL be all 0.
REQ-030 If the locked requester deasserts invld mid-packet, the FSM SHALL stay in LOCK and no other requester SHALL be accepted.
REQ-031 If no invld bit is set in ARB, no transfer SHALL occur and ptr SHALL be unchanged.
REQ-032 ptr SHALL change only on an accepted beat.

Reset
REQ-033 SHALL, while rst=0, force outvld=0, outdata=0, outlast=0, outidx=0, ptr=0, FSM=ARB and inrdy=0, independent of clk.
REQ-034 SHALL, on reset asserted mid-packet, discard the lock; after release, arbitration SHALL start from requester 0.

Verification
REQ-035 SHALL be checked with: N=4, ELOCK=0, all invld=1, single-beat traffic, outrdy=1 -> outidx sequence 0,1,2,3,0, one beat per cycle, first outvld one cycle after the first accept.
REQ-036 SHALL be checked with: ELOCK=1, req1 sends a 3-beat packet while req0 and req2 are valid -> outidx 1,1,1 contiguous, then 2, then 0.
REQ-037 SHALL be checked with: outrdy held 0 for 5 cycles while outvld=1, outdata=0xA5 -> outdata holds 0xA5 and inrdy=0 for all 5 cycles; beat transferred on the first cycle outrdy=1.
REQ-038 SHALL be checked with: locked req3 deasserts invld for 2 cycles while req0 is valid -> no beats accepted during the gap; req3 resumes and finishes its packet before req0 is granted.
REQ-039 SHALL be checked with: rst pulsed low mid-packet on req2 -> outvld=0 immediately; after release, with all invld=1, the first grant is to req0.
